// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and sizes for the display scheduler
package disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 20;

  // Index width for a source count; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dd_step.sv
// rtl/dd_step.sv - one double-dabble iteration: add 3 to nibbles >= 5, then shift left
module dd_step
  import disp_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [BCD_W+W-1:0] din_i,
  output logic [BCD_W+W-1:0] dout_o
);

  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bcd_adj = din_i[BCD_W+W-1:W];
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_adj[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_adj[d*4 +: 4] + 4'd3;
      end
    end
    dout_o = {bcd_adj, din_i[W-1:0]} << 1;
  end

endmodule

// File: rtl/disp_scheduler.sv
// rtl/disp_scheduler.sv - round-robin source selection and signed BCD conversion
// for a shared 5-digit 7-segment display
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int W     = 11,
  parameter int DWELL = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*W-1:0]        src_data,
  input  logic                      hold,
  output logic [BCD_W-1:0]          bcd_out,
  output logic                      sig_out,
  output logic [sel_w(N_SRC)-1:0]   sel_out,
  output logic                      disp_update,
  output logic                      busy
);

  localparam int SW  = sel_w(N_SRC);
  localparam int CW  = $clog2(W + 1);
  localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SRW = BCD_W + W;

  state_t           state_q, state_d;
  logic [SW-1:0]    last_q, last_d;
  logic             pos_q, pos_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             sig_q, sig_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             upd_q, upd_d;

  logic [SW-1:0]    grant;
  logic [W-1:0]     gdata;
  logic [W-1:0]     mag;
  logic             hi_found;
  logic [SRW-1:0]   step;

  dd_step #(.W(W)) u_dd_step (
    .din_i  (sr_q),
    .dout_o (step)
  );

  // Prefer the lowest valid index above last; otherwise wrap to the lowest at or below it.
  always_comb begin
    grant    = last_q;
    gdata    = src_data[W-1:0];
    hi_found = 1'b0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (src_valid[j] && (j > int'(last_q))) begin
        hi_found = 1'b1;
        grant    = SW'(j);
        gdata    = src_data[j*W +: W];
      end
    end
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (!hi_found && src_valid[j] && (j <= int'(last_q))) begin
        grant = SW'(j);
        gdata = src_data[j*W +: W];
      end
    end
    mag = gdata[W-1] ? (~gdata + {{(W-1){1'b0}}, 1'b1}) : gdata;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pos_d   = pos_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    bcd_d   = bcd_q;
    sig_d   = sig_q;
    sel_d   = sel_q;
    upd_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|src_valid) begin
          sr_d    = {{BCD_W{1'b0}}, mag};
          pos_d   = ~gdata[W-1];
          cnt_d   = CW'(W);
          last_d  = grant;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = step;
        cnt_d = cnt_q - CW'(1);
        // Final shift: publish all three outputs together from the fresh result.
        if (cnt_q == CW'(1)) begin
          bcd_d   = step[SRW-1:W];
          sig_d   = pos_q;
          sel_d   = last_q;
          upd_d   = 1'b1;
          dwell_d = DW'(DWELL - 1);
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else if (!hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SW'(N_SRC - 1);
      pos_q   <= 1'b1;
      sr_q    <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      bcd_q   <= '0;
      sig_q   <= 1'b1;
      sel_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pos_q   <= pos_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      bcd_q   <= bcd_d;
      sig_q   <= sig_d;
      sel_q   <= sel_d;
      upd_q   <= upd_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign sig_out     = sig_q;
  assign sel_out     = sel_q;
  assign disp_update = upd_q;
  assign busy        = (state_q == CONV);

endmodule

// File: tb/tb_disp_scheduler.sv
// tb/tb_disp_scheduler.sv - directed self-checking bench for disp_scheduler
module tb_disp_scheduler;

  localparam int N_SRC = 3;
  localparam int W     = 11;
  localparam int DWELL = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N_SRC-1:0]     src_valid;
  logic [N_SRC*W-1:0]   src_data;
  logic                 hold;
  logic [19:0]          bcd_out;
  logic                 sig_out;
  logic [1:0]           sel_out;
  logic                 disp_update;
  logic                 busy;

  int total = 0;
  int bad   = 0;
  int n, nb, upd_seen, sel_moved, busy_seen;

  disp_scheduler #(.N_SRC(N_SRC), .W(W), .DWELL(DWELL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .hold        (hold),
    .bcd_out     (bcd_out),
    .sig_out     (sig_out),
    .sel_out     (sel_out),
    .disp_update (disp_update),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input int v);
    src_data[i*W +: W] = v[W-1:0];
  endtask

  // Negedges until disp_update is seen (-1 on timeout); also counts busy samples.
  task automatic wait_upd(output int cyc, output int nbusy);
    cyc   = -1;
    nbusy = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (disp_update) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    src_valid = '0;
    src_data  = '0;

    // Reset state, with a source already valid.
    set_src(0, 1023);
    src_valid = 3'b001;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd_out, 20'h00000);
    chk("rst_sig", sig_out, 1);
    chk("rst_sel", sel_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", disp_update, 0);

    // Positive limit.
    rst_n = 1'b1;
    wait_upd(n, nb);
    chk("pos_latency", n, 12);
    chk("pos_busy_cycles", nb, 11);
    chk("pos_bcd", bcd_out, 20'h01023);
    chk("pos_sig", sig_out, 1);
    chk("pos_sel", sel_out, 0);
    set_src(0, -1024);
    @(negedge clk);
    chk("pos_pulse_width", disp_update, 0);

    // Negative limit, single source re-granted.
    wait_upd(n, nb);
    chk("neg_period", n, 15);
    chk("neg_bcd", bcd_out, 20'h01024);
    chk("neg_sig", sig_out, 0);

    // Zero; data changed after capture must not leak in.
    set_src(0, 0);
    busy_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_seen = 1;
        break;
      end
    end
    chk("zero_busy_seen", busy_seen, 1);
    set_src(0, 500);
    wait_upd(n, nb);
    chk("zero_bcd", bcd_out, 20'h00000);
    chk("zero_sig", sig_out, 1);
    wait_upd(n, nb);
    chk("late_period", n, 16);
    chk("late_bcd", bcd_out, 20'h00500);
    chk("late_sig", sig_out, 1);

    // Round robin over three sources.
    do_reset();
    set_src(0, 5);
    set_src(1, -7);
    set_src(2, 0);
    src_valid = 3'b111;
    rst_n = 1'b1;
    wait_upd(n, nb);
    chk("rr0_latency", n, 12);
    chk("rr0_sel", sel_out, 0);
    chk("rr0_bcd", bcd_out, 20'h00005);
    chk("rr0_sig", sig_out, 1);
    wait_upd(n, nb);
    chk("rr1_period", n, 16);
    chk("rr1_sel", sel_out, 1);
    chk("rr1_bcd", bcd_out, 20'h00007);
    chk("rr1_sig", sig_out, 0);
    wait_upd(n, nb);
    chk("rr2_period", n, 16);
    chk("rr2_sel", sel_out, 2);
    chk("rr2_bcd", bcd_out, 20'h00000);
    chk("rr2_sig", sig_out, 1);
    wait_upd(n, nb);
    chk("rr3_period", n, 16);
    chk("rr3_sel", sel_out, 0);

    // Skip invalid source 0, then hold.
    do_reset();
    set_src(1, 12);
    set_src(2, -345);
    src_valid = 3'b110;
    rst_n = 1'b1;
    wait_upd(n, nb);
    chk("skip1_sel", sel_out, 1);
    chk("skip1_bcd", bcd_out, 20'h00012);
    wait_upd(n, nb);
    chk("skip2_period", n, 16);
    chk("skip2_sel", sel_out, 2);
    chk("skip2_bcd", bcd_out, 20'h00345);
    chk("skip2_sig", sig_out, 0);
    hold      = 1'b1;
    upd_seen  = 0;
    sel_moved = 0;
    busy_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (disp_update) upd_seen++;
      if (sel_out !== 2'd2) sel_moved++;
      if (busy) busy_seen++;
    end
    chk("hold_no_update", upd_seen, 0);
    chk("hold_sel_fixed", sel_moved, 0);
    chk("hold_no_busy", busy_seen, 0);
    hold = 1'b0;
    wait_upd(n, nb);
    chk("release_latency", n, 13);
    chk("release_busy_cycles", nb, 11);
    chk("release_sel", sel_out, 1);

    // Reset during conversion cycle 5.
    do_reset();
    set_src(0, 999);
    set_src(1, -1);
    set_src(2, 3);
    src_valid = 3'b111;
    rst_n = 1'b1;
    wait_upd(n, nb);
    chk("mid_pre_bcd", bcd_out, 20'h00999);
    nb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (nb == 5) break;
    end
    chk("mid_conv_cycles", nb, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd_out, 20'h00000);
    chk("mid_rst_sig", sig_out, 1);
    chk("mid_rst_sel", sel_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", disp_update, 0);
    set_src(0, -256);
    @(negedge clk);
    rst_n = 1'b1;
    wait_upd(n, nb);
    chk("mid_after_latency", n, 12);
    chk("mid_after_sel", sel_out, 0);
    chk("mid_after_bcd", bcd_out, 20'h00256);
    chk("mid_after_sig", sig_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

- Time-shares the board's 5-digit signed 7-segment display between `N_SRC` CORDIC result sources, such as x, y and angle.
- Round-robin selection grants each valid source a dwell period.
- The selected 11-bit signed value is converted to sign plus 5 BCD digits with a sequential double-dabble (one shift per cycle).
- Registered digits feed the existing `bcd_to_7seg` decoder instances at top level.

## Interface
Parameters:
- `N_SRC`, 3: number of requesting sources (2..8).
- `W`, 11: signed data width per source.
- `DWELL`, 50_000_000: cycles each source stays on display (≥1).

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `src_valid`  in  N_SRC: source i has a displayable value.
- `src_data`  in  N_SRC*W: packed signed values; source i at bits `[i*W +: W]`.
- `hold`  in  1: freezes the current source on display.
- `bcd_out`  out  20: digits {d4,d3,d2,d1,d0}, 4 bits each, d0 = units.
- `sig_out`  out  1: 1 = positive/zero, 0 = negative.
- `sel_out`  out  $clog2(N_SRC): index of the displayed source.
- `disp_update`  out  1: one-cycle pulse when the outputs change.
- `busy`  out  1: high while in CONV.

## Operation
FSM states are IDLE, CONV and SHOW. Reset enters IDLE.

IDLE:
- If no `src_valid` bit is set, stay in IDLE; outputs keep their last values.
- Otherwise grant the first valid index searching from `last+1` modulo N_SRC.
- Capture `src_data` of the grant.
- Store the sign and the magnitude (two's complement if negative). Magnitude is W bits unsigned, so -1024 gives 1024.
- Load the shift counter with W, set `last` to the grant, and go to CONV.

CONV:
- Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, mag} left by 1.
- After W shifts, load `bcd_out`, `sig_out` and `sel_out` together from the final result in the same edge.
- Pulse `disp_update`, load the dwell counter with DWELL-1, and go to SHOW.

SHOW:
- The dwell counter decrements each cycle and saturates at 0.
- When the counter is 0 and `hold`=0, go to IDLE.
- If `hold`=1, remain in SHOW. The counter still runs down to 0, so release exits on the next cycle.
- A source dropping `src_valid` during CONV or SHOW does not abort the conversion or the dwell.

General rules:
- Data changes on the captured source after capture are ignored until the next grant.
- If only one source is valid, it is re-granted each period, refreshing its value.
- Reset values: `bcd_out`=0, `sig_out`=1, `sel_out`=0, `disp_update`=0, `busy`=0, `last`=N_SRC-1 (so source 0 wins first).
- An asynchronous reset in any state forces IDLE and the reset values immediately. Any partial conversion is discarded.

## Timing
- Capture edge to output-load edge: exactly W cycles (11).
- `disp_update` is high for the first SHOW cycle only.
- Steady-state period per source with `hold`=0: 1 (IDLE) + W (CONV) + DWELL (SHOW) cycles.
- `busy` is high for exactly W cycles per conversion.
- `bcd_out`, `sig_out` and `sel_out` never show a partial conversion; all three change on the same edge.
- Maximum magnitude is 2^(W-1) = 1024. It fits in 4 digits; d4 is always 0 at W=11 but is still produced.

## Structure
- Package `disp_pkg`:
  - state enum {IDLE, CONV, SHOW};
  - `BCD_DIGITS`=5;
  - `BCD_W`=20;
  - function `sel_w(N)` = $clog2(N), minimum 1.
- Sub-module `dd_step`: combinational add-3-and-shift for one iteration. Input is {bcd[19:0], mag[W-1:0]}; output is the same width. CONV registers its output each cycle.
- The round-robin next-index search stays inline.
- Segment decoding stays outside this block, in the existing decoders.

## Test plan
- **Reset:** hold `rst_n`=0 → `bcd_out`=20'h00000, `sig_out`=1, `sel_out`=0, `busy`=0.
- **Positive limit:** only src0 valid, value 11'sd1023 → 11 cycles after capture, `bcd_out`=20'h01023, `sig_out`=1, `sel_out`=0, `disp_update` is a 1-cycle pulse.
- **Negative limit:** src0 = 11'h400 (-1024) → `bcd_out`=20'h01024, `sig_out`=0. Also src0 = 0 → `bcd_out`=0, `sig_out`=1.
- **Round robin:** DWELL=4, sources 5, -7, 0 all valid → `sel_out` goes 0,1,2,0 with `disp_update` every 16 cycles. Values shown are 20'h00005/sig 1, 20'h00007/sig 0, 20'h00000/sig 1.
- **Skip and hold:** only src1 and src2 valid → sequence 1,2,1. Asserting `hold` for 100 cycles in SHOW keeps `sel_out` fixed with no `disp_update`. Release → IDLE on the next cycle.
- **Reset mid-conversion:** pulse `rst_n` low during CONV cycle 5 → outputs return to reset values at once. After release, the next grant is source 0 with a correct full conversion.
